// File: rtl/prog_mem_if.sv
// prog_mem_if: bundles the instruction-fetch port and the loader write port
// of prog_mem.
//   master : fetch stage / boot or debug loader (drives requests and writes)
//   slave  : prog_mem
// Fetch:  if_req/if_addr/if_ready request handshake, if_valid/if_rdata/if_err
//         response, if_ack consumer handshake.
// Load:   ld_we/ld_addr/ld_wdata/ld_be byte-enabled write, ld_lock sticky lock
//         pulse, locked status, ld_err dropped-write pulse.
interface prog_mem_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096
);
  localparam int BE_W   = DATA_W / 8;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int ADDR_W = $clog2(DEPTH) + OFF_W;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;
  logic              if_ack;

  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [BE_W-1:0]   ld_be;
  logic              ld_lock;
  logic              locked;
  logic              ld_err;

  modport master (
    output if_req, if_addr, if_ack, ld_we, ld_addr, ld_wdata, ld_be, ld_lock,
    input  if_ready, if_valid, if_rdata, if_err, locked, ld_err
  );

  modport slave (
    input  if_req, if_addr, if_ack, ld_we, ld_addr, ld_wdata, ld_be, ld_lock,
    output if_ready, if_valid, if_rdata, if_err, locked, ld_err
  );
endinterface

// File: rtl/prog_mem.sv
// prog_mem: program memory with a pipelined, back-pressured fetch port and a
// byte-enabled load port guarded by a sticky write lock.
// Ports:
//   clk_i  : single clock, rising edge
//   rst_i  : synchronous active-high reset (flushes the read pipeline, clears
//            lock and ld_err; memory contents are kept)
//   bus    : prog_mem_if slave modport (fetch and load signals)
// Parameters: DATA_W (multiple of 8, >= 16), DEPTH (any), RD_LATENCY (1..4).
module prog_mem #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4096,
  parameter int RD_LATENCY = 1
) (
  input logic        clk_i,
  input logic        rst_i,
  prog_mem_if.slave  bus
);
  localparam int BE_W   = DATA_W / 8;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int ADDR_W = IDX_W + OFF_W;
  // One bit wider than an index so DEPTH itself is representable.
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);

  logic [DATA_W-1:0]     mem_q [DEPTH];

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [RD_LATENCY-1:0] err_q, err_d;
  logic [DATA_W-1:0]     data_q [RD_LATENCY];
  logic [DATA_W-1:0]     data_d [RD_LATENCY];
  logic                  locked_q, locked_d;
  logic                  ld_err_q, ld_err_d;

  logic [IDX_W-1:0]      f_idx, w_idx;
  logic                  f_bad, w_oor;
  logic                  advance, accept, wr_en;
  logic                  unused_ld_off;

  assign f_idx = bus.if_addr[ADDR_W-1:OFF_W];
  assign f_bad = ({1'b0, f_idx} >= DEPTH_C) || (bus.if_addr[OFF_W-1:0] != '0);
  assign w_idx = bus.ld_addr[ADDR_W-1:OFF_W];
  assign w_oor = ({1'b0, w_idx} >= DEPTH_C);
  // Load addresses are word-granular; the byte offset is intentionally ignored.
  assign unused_ld_off = ^bus.ld_addr[OFF_W-1:0];

  // The whole pipeline moves in lock-step; it only stalls when the output
  // stage holds a result the consumer has not taken. This is also if_ready,
  // so ready never depends on if_req/if_addr.
  assign advance = !vld_q[RD_LATENCY-1] || bus.if_ack;
  assign accept  = bus.if_req && advance;

  always_comb begin
    vld_d  = vld_q;
    err_d  = err_q;
    data_d = data_q;
    if (advance) begin
      vld_d[0]  = accept;
      err_d[0]  = accept && f_bad;
      // Bad fetches never touch the array and return zero data.
      data_d[0] = (accept && !f_bad) ? mem_q[f_idx] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_d[i]  = vld_q[i-1];
        err_d[i]  = err_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end
  end

  // Lock is checked against the registered value, so a write in the same
  // cycle as the lock pulse still lands.
  assign wr_en    = bus.ld_we && !locked_q && !w_oor;
  assign ld_err_d = bus.ld_we && (bus.ld_be != '0) && !wr_en;
  assign locked_d = locked_q || bus.ld_lock;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q    <= '0;
      err_q    <= '0;
      for (int i = 0; i < RD_LATENCY; i++) data_q[i] <= '0;
      locked_q <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      err_q    <= err_d;
      for (int i = 0; i < RD_LATENCY; i++) data_q[i] <= data_d[i];
      locked_q <= locked_d;
      ld_err_q <= ld_err_d;
    end
  end

  // Array is not reset. Stage 0 samples mem_q before this update, which
  // gives read-before-write on a same-cycle collision.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.ld_be[b]) mem_q[w_idx][8*b +: 8] <= bus.ld_wdata[8*b +: 8];
      end
    end
  end

  assign bus.if_ready = advance;
  assign bus.if_valid = vld_q[RD_LATENCY-1];
  assign bus.if_err   = err_q[RD_LATENCY-1];
  assign bus.if_rdata = data_q[RD_LATENCY-1];
  assign bus.locked   = locked_q;
  assign bus.ld_err   = ld_err_q;
endmodule

// File: doc/prog_mem.md
# prog_mem

Parametrised program memory, the successor to the single-port combinational-read ROM. It has a pipelined, back-pressured instruction-fetch port and a separate byte-enabled load port with a write lock. It sits between the fetch stage (read side) and the boot loader / debug loader (write side). Depth, data width and read latency are set at elaboration. Out-of-range and misaligned fetches are flagged, not silently aliased.

## Interface
- DATA_W, 32, data word width in bits; multiple of 8, at least 16.
- DEPTH, 4096, number of words; need not be a power of two.
- RD_LATENCY, 1, cycles from accepted request to valid data; legal range 1..4.
- BE_W, DATA_W/8, derived; byte lanes per word.
- OFF_W, clog2(BE_W), derived; byte-offset bits.
- ADDR_W, clog2(DEPTH)+OFF_W, derived; byte-address width.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch byte address.
- if_ready  out  1  request accepted this cycle when if_req && if_ready.
- if_valid  out  1  if_rdata/if_err valid.
- if_rdata  out  DATA_W  fetched word.
- if_err  out  1  fetch was out of range or misaligned.
- if_ack  in  1  consumer takes the output; an output transfer occurs when if_valid && if_ack.
- ld_we  in  1  load write strobe.
- ld_addr  in  ADDR_W  load byte address; offset bits ignored.
- ld_wdata  in  DATA_W  load data.
- ld_be  in  BE_W  byte enables; bit i writes ld_wdata[8i+7:8i].
- ld_lock  in  1  a one-cycle pulse sets the sticky lock.
- locked  out  1  writes are blocked; cleared only by rst.
- ld_err  out  1  one-cycle pulse: the previous-cycle write was dropped.

## Operation
- Word index is addr[ADDR_W-1:OFF_W]. An index of DEPTH or above is out of range.
- **Read pipeline**
  - RD_LATENCY stages. Each stage holds valid, data and err.
  - Stage 0 captures the memory read of an accepted request.
  - The pipeline advances when the output stage is empty or if_ack is high. Otherwise every stage holds.
  - if_ready equals that advance condition. A request is never dropped; one request per cycle is accepted when no stall is present.
- **Fetch error**
  - Condition: out of range, or the offset bits are nonzero.
  - Response: if_err=1 and if_rdata=0. The memory array is not accessed.
- **Write**
  - Occurs when ld_we && !locked && index in range. Only enabled bytes are updated at the clock edge.
  - A write that is blocked (locked or out of range) is dropped. ld_err pulses in the following cycle.
  - ld_be=0 with ld_we=1 is a legal no-op and does not raise ld_err.
- **Same-cycle fetch and write to the same word**: the fetch returns the pre-write contents (read-before-write). The next fetch sees the new data.
- **Lock**: ld_lock and ld_we in the same cycle means the write is performed, then locked=1 from the next cycle.
- **Reset values**
  - if_valid=0, if_rdata=0, if_err=0, locked=0, ld_err=0.
  - All pipeline valids are cleared, so in-flight fetches are flushed.
  - Memory contents are not cleared.
  - if_ready=1 in the first cycle after reset.
  - Reset asserted mid-stall discards held data.

## Timing
- With no stall, a request accepted at edge t gives if_valid=1 during cycle t+RD_LATENCY.
- Back-to-back requests give back-to-back results at full throughput.
- if_ready is a combinational function of the output-stage valid and if_ack only. It has no path from if_req or if_addr.
- While if_valid=1 and if_ack=0, if_rdata and if_err are held stable.
- A write at edge t is visible to a fetch accepted at edge t+1 or later.
- ld_err is registered: it is high for exactly one cycle after the dropped write.

## Test plan
- **Basic write/read.** Reset; write 0xDEADBEEF to byte address 0x10 with be=0xF; fetch 0x10 at RD_LATENCY=2 -> if_valid two cycles after acceptance, rdata=0xDEADBEEF, err=0.
- **Byte enables.** With word 0x10=0xDEADBEEF, write 0x11223344 with be=0b0101 -> fetch returns 0xDE22BE44.
- **Back-pressure.** Issue 4 consecutive fetches; hold if_ack=0 for 3 cycles once if_valid rises -> if_ready=0 while stalled, data held stable, all 4 words delivered in order with none lost or duplicated.
- **Errors.** DEPTH=1000: fetch byte address 4000 (word index 1000) -> err=1, rdata=0. Fetch 0x13 -> err=1. Write to word index 1000 -> memory unchanged, ld_err pulses once.
- **Collision and lock.** Same-cycle write 0x5 and fetch of the same word holding 0x9 -> returns 0x9; the next fetch returns 0x5. Pulse ld_lock with a write of 0x7 -> the write lands, locked=1, a later write is dropped with an ld_err pulse, and rst clears locked.
- **Reset mid-flight.** Assert rst while 2 fetches are in flight and stalled -> if_valid=0 the next cycle, no stale data is ever presented, if_ready=1 after reset.
